// File: rtl/sdhci_cmd_pkg.sv
// Shared constants, state encoding and CRC7 step function for the SD command transmit path.
package sdhci_cmd_pkg;

  localparam int CMD_FRAME_BITS   = 48;
  localparam int CMD_PAYLOAD_BITS = 40;
  localparam int CRC7_BITS        = 7;
  localparam int CMD_LISTEN_DELAY = 2;

  // x^7 + x^3 + 1, with the x^7 term implicit in the feedback
  localparam logic [CRC7_BITS-1:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    IDLE,
    SEND_DATA,
    SEND_CRC,
    SEND_END,
    WAIT_LISTEN,
    DONE
  } cmd_tx_state_e;

  // One serial CRC7 step: fold a single message bit into the running remainder.
  function automatic logic [CRC7_BITS-1:0] crc7_step(input logic [CRC7_BITS-1:0] crc,
                                                     input logic bit_in);
    logic feedback;
    feedback  = crc[CRC7_BITS-1] ^ bit_in;
    crc7_step = {crc[CRC7_BITS-2:0], 1'b0} ^ (feedback ? CRC7_POLY : '0);
  endfunction

endpackage

// File: rtl/crc7_write.sv
// Serial CRC7 generator: accumulates the command payload bit by bit, then shifts the result out MSB first.
module crc7_write
  import sdhci_cmd_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clk_en_i,
  input  logic                 clear_i,
  input  logic                 update_i,
  input  logic                 shift_i,
  input  logic                 bit_i,
  output logic [CRC7_BITS-1:0] crc_o
);

  logic [CRC7_BITS-1:0] crc_q;
  logic [CRC7_BITS-1:0] crc_d;

  // Next remainder: clear wins, then accumulate a payload bit, then shift out towards the MSB.
  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (update_i) begin
      crc_d = crc7_step(crc_q, bit_i);
    end else if (shift_i) begin
      crc_d = {crc_q[CRC7_BITS-2:0], 1'b0};
    end
  end

  // Remainder register, advancing only on SD clock ticks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= '0;
    end else if (clk_en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/cmd_write.sv
// SD command frame serialiser: start, transmission, index, argument, CRC7 and end bit onto the CMD line,
// followed by an optional start-of-listening strobe for the response receiver.
module cmd_write
  import sdhci_cmd_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clk_en_i,
  input  logic        start_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  input  logic        rsp_expected_i,
  output logic        cmd_o,
  output logic        cmd_en_o,
  output logic        busy_o,
  output logic        start_listening_o,
  output logic        done_o
);

  localparam logic [5:0] LastDataCnt   = 6'(CMD_PAYLOAD_BITS - 1);
  localparam logic [5:0] LastCrcCnt    = 6'(CRC7_BITS - 1);
  localparam logic [5:0] LastListenCnt = 6'(CMD_LISTEN_DELAY - 1);

  cmd_tx_state_e                state_q, state_d;
  logic [CMD_PAYLOAD_BITS-1:0]  shift_q, shift_d;
  logic [5:0]                   cnt_q, cnt_d;
  logic                         rsp_q, rsp_d;
  logic                         cmd_q, cmd_d;
  logic                         cmd_en_q, cmd_en_d;
  logic                         busy_q, busy_d;
  logic                         listen_q, listen_d;
  logic                         done_q, done_d;

  logic                         crc_clear;
  logic                         crc_update;
  logic                         crc_shift;
  logic [CRC7_BITS-1:0]         crc;
  logic [CRC7_BITS-1:0]         crc_final;

  crc7_write u_crc7_write (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clk_en_i (clk_en_i),
    .clear_i  (crc_clear),
    .update_i (crc_update),
    .shift_i  (crc_shift),
    .bit_i    (shift_q[CMD_PAYLOAD_BITS-1]),
    .crc_o    (crc)
  );

  // The CRC register only holds the full remainder one tick after the last payload bit, so the
  // first CRC bit is taken from the remainder as it will be once that bit is folded in.
  assign crc_final = crc7_step(crc, shift_q[CMD_PAYLOAD_BITS-1]);

  // Next-state and next-output logic; outputs are computed for the value they must show after this tick.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    rsp_d      = rsp_q;
    cmd_d      = cmd_q;
    cmd_en_d   = cmd_en_q;
    busy_d     = busy_q;
    listen_d   = 1'b0;
    done_d     = 1'b0;
    crc_clear  = 1'b0;
    crc_update = 1'b0;
    crc_shift  = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_d    = 1'b1;
        cmd_en_d = 1'b0;
        if (start_i) begin
          state_d   = SEND_DATA;
          shift_d   = {2'b01, cmd_index_i, cmd_arg_i};
          rsp_d     = rsp_expected_i;
          cnt_d     = '0;
          crc_clear = 1'b1;
          busy_d    = 1'b1;
          cmd_en_d  = 1'b1;
          cmd_d     = shift_d[CMD_PAYLOAD_BITS-1];
        end
      end

      SEND_DATA: begin
        crc_update = 1'b1;
        shift_d    = {shift_q[CMD_PAYLOAD_BITS-2:0], 1'b0};
        if (cnt_q == LastDataCnt) begin
          state_d = SEND_CRC;
          cnt_d   = '0;
          cmd_d   = crc_final[CRC7_BITS-1];
        end else begin
          cnt_d = cnt_q + 6'd1;
          cmd_d = shift_q[CMD_PAYLOAD_BITS-2];
        end
      end

      SEND_CRC: begin
        crc_shift = 1'b1;
        if (cnt_q == LastCrcCnt) begin
          state_d = SEND_END;
          cnt_d   = '0;
          cmd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
          cmd_d = crc[CRC7_BITS-2];
        end
      end

      SEND_END: begin
        cmd_d    = 1'b1;
        cmd_en_d = 1'b0;
        cnt_d    = '0;
        if (rsp_q) begin
          state_d = WAIT_LISTEN;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      WAIT_LISTEN: begin
        if (cnt_q == LastListenCnt) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q + 6'd1;
          listen_d = (cnt_q == LastListenCnt - 6'd1);
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        cmd_d    = 1'b1;
        cmd_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; everything holds between SD clock ticks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      rsp_q    <= 1'b0;
      cmd_q    <= 1'b1;
      cmd_en_q <= 1'b0;
      busy_q   <= 1'b0;
      listen_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (clk_en_i) begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      rsp_q    <= rsp_d;
      cmd_q    <= cmd_d;
      cmd_en_q <= cmd_en_d;
      busy_q   <= busy_d;
      listen_q <= listen_d;
      done_q   <= done_d;
    end
  end

  assign cmd_o             = cmd_q;
  assign cmd_en_o          = cmd_en_q;
  assign busy_o            = busy_q;
  assign start_listening_o = listen_q;
  assign done_o            = done_q;

endmodule

// File: tb/tb_cmd_write.sv
// Bench for cmd_write: known command frames from a table, multi-cycle corner sequences and
// randomised frames, all compared tick by tick against a frame-level reference model.
module tb_cmd_write;
  import sdhci_cmd_pkg::*;

  typedef logic [CMD_FRAME_BITS-1:0] frame_t;

  typedef struct packed {
    logic cmd;
    logic en;
    logic busy;
    logic listen;
    logic done;
  } outs_t;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    bit          rsp;
    int          div;
    frame_t      frame;
  } vec_t;

  localparam outs_t RESET_OUTS = 5'b10000;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        clk_en  = 1'b0;
  logic        start   = 1'b0;
  logic [5:0]  idx_in  = '0;
  logic [31:0] arg_in  = '0;
  logic        rsp_in  = 1'b0;

  logic        cmd_o;
  logic        cmd_en_o;
  logic        busy_o;
  logic        listen_o;
  logic        done_o;

  int          n_cmp   = 0;
  int          n_bad   = 0;

  // Reference model state: k = ticks elapsed since the accepting tick, 0 when idle.
  int          k       = 0;
  bit          m_rsp   = 1'b0;
  frame_t      m_frame = '0;

  // Frame as seen on the wire while the DUT drives the line.
  frame_t      cap     = '0;
  int          en_cnt  = 0;

  cmd_write dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .clk_en_i          (clk_en),
    .start_i           (start),
    .cmd_index_i       (idx_in),
    .cmd_arg_i         (arg_in),
    .rsp_expected_i    (rsp_in),
    .cmd_o             (cmd_o),
    .cmd_en_o          (cmd_en_o),
    .busy_o            (busy_o),
    .start_listening_o (listen_o),
    .done_o            (done_o)
  );

  always #5 clk = ~clk;

  // Hard stop in case the stimulus itself ever stalls.
  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no summary required summary");
    $fatal(1, "[TB] watchdog");
  end

  // Frame built from the command rules: CRC7 as the remainder of polynomial long division.
  function automatic frame_t model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] payload;
    logic [46:0] rem;
    payload = {2'b01, idx, arg};
    rem     = {payload, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (rem[i]) rem = rem ^ (47'h89 << (i - 7));
    end
    return {payload, rem[6:0], 1'b1};
  endfunction

  // Expected outputs during the tick that lies 'kk' ticks after acceptance.
  function automatic outs_t model_outs(input int kk, input bit rsp, input frame_t frame);
    outs_t o;
    int    last;
    o    = RESET_OUTS;
    last = rsp ? 51 : 49;
    if (kk >= 1 && kk <= last) o.busy = 1'b1;
    if (kk >= 1 && kk <= 48) begin
      o.en  = 1'b1;
      o.cmd = frame[48 - kk];
    end
    if (rsp && kk == 50) o.listen = 1'b1;
    if (kk == last) o.done = 1'b1;
    return o;
  endfunction

  task automatic checkOutput(input string name, input outs_t got, input outs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s k=%0d cmd/en/busy/listen/done got=%b required=%b", name, k, got, exp);
    end
  endtask

  task automatic checkValue(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // One SD tick preceded by div-1 stalled cycles; outputs are checked on every cycle.
  task automatic applyStimulus(input int div, input bit st, input logic [5:0] idx,
                               input logic [31:0] arg, input bit rsp);
    outs_t exp;
    outs_t got;
    int    last;
    exp = model_outs(k, m_rsp, m_frame);
    for (int c = 0; c < div; c++) begin
      @(negedge clk);
      got = {cmd_o, cmd_en_o, busy_o, listen_o, done_o};
      checkOutput((c == div - 1) ? "tick" : "hold", got, exp);
      if (c == div - 1) begin
        if (cmd_en_o === 1'b1) begin
          cap = {cap[CMD_FRAME_BITS-2:0], cmd_o};
          en_cnt++;
        end
        clk_en = 1'b1;
        start  = st;
        idx_in = idx;
        arg_in = arg;
        rsp_in = rsp;
      end else begin
        clk_en = 1'b0;
        start  = 1'($urandom);
        idx_in = 6'($urandom);
        arg_in = $urandom;
        rsp_in = 1'($urandom);
      end
    end
    last = m_rsp ? 51 : 49;
    if (k == 0) begin
      if (st) begin
        k       = 1;
        m_frame = model_frame(idx, arg);
        m_rsp   = rsp;
      end
    end else if (k == last) begin
      k = 0;
    end else begin
      k++;
    end
  endtask

  task automatic idleTick(input int div);
    applyStimulus(div, 1'b0, 6'($urandom), $urandom, 1'($urandom));
  endtask

  // Issue a command on the current (idle) tick and run until the model returns to idle.
  // pulse_at re-asserts start with junk fields at that tick; stall_at stretches that tick by 50 cycles.
  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg, input bit rsp,
                           input int div, input int pulse_at, input int stall_at);
    int guard;
    guard  = 0;
    cap    = '0;
    en_cnt = 0;
    applyStimulus(div, 1'b1, idx, arg, rsp);
    while (k != 0 && guard < 200) begin
      applyStimulus((k == stall_at) ? 51 : div, (k == pulse_at), 6'($urandom), $urandom,
                    1'($urandom));
      guard++;
    end
  endtask

  // Asynchronous reset asserted between clock edges; outputs must return to rest immediately.
  task automatic doReset();
    outs_t got;
    @(negedge clk);
    clk_en = 1'b0;
    start  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    got = {cmd_o, cmd_en_o, busy_o, listen_o, done_o};
    checkOutput("reset", got, RESET_OUTS);
    k = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t        vecs[3];
    logic [5:0]  r_idx;
    logic [31:0] r_arg;
    bit          r_rsp;
    int          r_div;
    int          r_pulse;
    int          r_gap;

    vecs[0] = '{6'd0,  32'h0000_0000, 1'b0, 1, 48'h40_0000_0000_95};
    vecs[1] = '{6'd8,  32'h0000_01AA, 1'b1, 1, 48'h48_0000_01AA_87};
    vecs[2] = '{6'd17, 32'h0000_0000, 1'b0, 4, 48'h51_0000_0000_55};

    doReset();
    repeat (3) idleTick(1);

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      run_frame(vecs[i].idx, vecs[i].arg, vecs[i].rsp, vecs[i].div, -1, -1);
      checkValue("table_frame", 64'(cap), 64'(vecs[i].frame));
      checkValue("table_en_ticks", 64'(en_cnt), 64'd48);
      repeat (2) idleTick(vecs[i].div);
    end

    $display("[TB] start while busy, then start on first idle tick");
    run_frame(6'd17, 32'h0, 1'b0, 1, 10, -1);
    checkValue("busy_ignore_frame", 64'(cap), 64'h51_0000_0000_55);
    run_frame(6'd0, 32'h0, 1'b0, 1, -1, -1);
    checkValue("back_to_back_frame", 64'(cap), 64'h40_0000_0000_95);
    repeat (2) idleTick(1);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(1, 1'b1, 6'd8, 32'h1AA, 1'b1);
    repeat (19) idleTick(1);
    doReset();
    repeat (6) idleTick(1);
    run_frame(6'd0, 32'h0, 1'b0, 1, -1, -1);
    checkValue("post_reset_frame", 64'(cap), 64'h40_0000_0000_95);
    repeat (2) idleTick(1);

    $display("[TB] stall during CRC");
    run_frame(6'd8, 32'h1AA, 1'b1, 1, -1, 44);
    checkValue("stall_frame", 64'(cap), 64'h48_0000_01AA_87);
    checkValue("stall_en_ticks", 64'(en_cnt), 64'd48);
    repeat (2) idleTick(1);

    $display("[TB] random frames");
    for (int r = 0; r < 10; r++) begin
      r_idx   = 6'($urandom);
      r_arg   = $urandom;
      r_rsp   = 1'($urandom);
      r_div   = $urandom_range(1, 3);
      r_pulse = $urandom_range(1, 51);
      r_gap   = $urandom_range(0, 3);
      run_frame(r_idx, r_arg, r_rsp, r_div, r_pulse, -1);
      checkValue("random_frame", 64'(cap), 64'(model_frame(r_idx, r_arg)));
      for (int g = 0; g < r_gap; g++) idleTick(r_div);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
